// File: rtl/sb_unpack_ctrl_if.sv
// sb_unpack_ctrl_if: job-control, SB-read and unpacker-control signals of the SB unpack sequencer.
//   i_start/i_base_addr/i_count/i_prec/i_signed : job request
//   i_ready / o_valid                           : value handshake with downstream
//   o_busy / o_done                             : job status
//   o_rd_en / o_rd_addr                         : SB row read (data next cycle)
//   o_load / o_s / o_n / o_se / o_ze            : unpacker controls
// Modports: master = job/consumer side, slave = the sequencer.
interface sb_unpack_ctrl_if #(
    parameter int unsigned N          = 16,
    parameter int unsigned SHIFT_BITS = 5,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned CNT_W      = 12
);
    logic                    i_start;
    logic [ADDR_W-1:0]       i_base_addr;
    logic [CNT_W-1:0]        i_count;
    logic [SHIFT_BITS-1:0]   i_prec;
    logic                    i_signed;
    logic                    i_ready;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_rd_en;
    logic [ADDR_W-1:0]       o_rd_addr;
    logic [1:0]              o_load;
    logic [SHIFT_BITS-1:0]   o_s;
    logic [SHIFT_BITS-2:0]   o_n;
    logic [N-1:0]            o_se;
    logic [N-1:0]            o_ze;
    logic                    o_valid;

    modport master (
        output i_start, i_base_addr, i_count, i_prec, i_signed, i_ready,
        input  o_busy, o_done, o_rd_en, o_rd_addr, o_load, o_s, o_n, o_se, o_ze, o_valid
    );

    modport slave (
        input  i_start, i_base_addr, i_count, i_prec, i_signed, i_ready,
        output o_busy, o_done, o_rd_en, o_rd_addr, o_load, o_s, o_n, o_se, o_ze, o_valid
    );
endinterface

// File: rtl/sb_unpack_ctrl.sv
// sb_unpack_ctrl: sequencer in front of the SB weight unpacker. Walks a stream of n-bit values packed
// back-to-back in N-bit SB rows, keeping a 2N-bit ping-pong register (slot0/slot1) fed with rows and
// presenting one value per cycle under valid/ready.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset; aborts any job
//   bus  - sb_unpack_ctrl_if.slave: job request, SB read, unpacker controls, value handshake
module sb_unpack_ctrl #(
    parameter int unsigned N          = 16,
    parameter int unsigned SHIFT_BITS = 5,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned CNT_W      = 12
) (
    input logic             clk,
    input logic             rst,
    sb_unpack_ctrl_if.slave bus
);
    localparam int unsigned RW    = CNT_W + SHIFT_BITS;
    localparam int unsigned LOG_N = $clog2(N);
    localparam int unsigned MSB   = SHIFT_BITS - 1;

    typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;
    state_e state_q, state_d;

    logic [SHIFT_BITS-1:0] prec_q, p_q, p_next, p_end;
    logic [CNT_W-1:0]      cnt_q;
    logic [RW-1:0]         rows_needed_q, rows_issued_q, rows_calc, prod;
    logic [1:0]            fill_q;
    logic [1:0]            ready_q, ready_d;
    logic                  rd_en_q, rd_slot_q;
    logic [ADDR_W-1:0]     rd_addr_q;
    logic [1:0]            load_q;
    logic                  done_q;
    logic [N-1:0]          se_q, ze_q, low_mask, se_calc, ze_calc;
    logic                  start_job, full_prec, slot_p, valid, hs, consumed, refill, last;

    // Job parameters derived from the request
    always_comb begin
        prod      = RW'(bus.i_count) * RW'(bus.i_prec);
        rows_calc = (prod + RW'(N - 1)) >> LOG_N;
        full_prec = (bus.i_prec == SHIFT_BITS'(N));
        low_mask  = full_prec ? '1 : ((N'(1) << bus.i_prec) - N'(1));
        se_calc   = (bus.i_signed && !full_prec) ? ~low_mask : '0;
        ze_calc   = (bus.i_signed && !full_prec) ? '1 : low_mask;
    end

    // Value window p..p+n-1 wraps mod 2N; the top pointer bit selects the slot.
    always_comb begin
        start_job = (state_q == StIdle) && bus.i_start;
        slot_p    = p_q[MSB];
        p_next    = p_q + prec_q;
        p_end     = p_next - SHIFT_BITS'(1);
        valid     = (state_q == StRun) && ready_q[slot_p] && ready_q[p_end[MSB]];
        hs        = valid && bus.i_ready;
        // Leaving slot(p) means every bit of it has been used
        consumed  = hs && (p_next[MSB] != slot_p);
        refill    = consumed && (rows_issued_q < rows_needed_q);
        last      = hs && (cnt_q == CNT_W'(1));
    end

    always_comb begin
        ready_d = ready_q | load_q;
        if (start_job) ready_d = '0;
        if (consumed) ready_d[slot_p] = 1'b0;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_job && bus.i_count != '0) state_d = StFill;
            StFill:  if (fill_q == 2'd2) state_d = StRun;
            StRun:   if (last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.o_busy    = (state_q != StIdle);
        bus.o_valid   = valid;
        bus.o_done    = done_q;
        bus.o_rd_en   = rd_en_q;
        bus.o_rd_addr = rd_addr_q;
        bus.o_load    = load_q;
        bus.o_s       = p_q;
        bus.o_n       = prec_q[SHIFT_BITS-2:0];
        bus.o_se      = se_q;
        bus.o_ze      = ze_q;
    end

    // Datapath: job registers, read issue, load strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prec_q        <= '0;
            p_q           <= '0;
            cnt_q         <= '0;
            rows_needed_q <= '0;
            rows_issued_q <= '0;
            fill_q        <= '0;
            ready_q       <= '0;
            rd_en_q       <= 1'b0;
            rd_slot_q     <= 1'b0;
            rd_addr_q     <= '0;
            load_q        <= '0;
            done_q        <= 1'b0;
            se_q          <= '0;
            ze_q          <= '0;
        end else begin
            ready_q <= ready_d;
            // SB data arrives the cycle after the read; strobe the slot it was issued for
            load_q  <= rd_en_q ? (rd_slot_q ? 2'b10 : 2'b01) : 2'b00;
            done_q  <= (start_job && bus.i_count == '0) || last;
            rd_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_job && bus.i_count != '0) begin
                        prec_q        <= bus.i_prec;
                        cnt_q         <= bus.i_count;
                        rows_needed_q <= rows_calc;
                        se_q          <= se_calc;
                        ze_q          <= ze_calc;
                        p_q           <= '0;
                        fill_q        <= '0;
                        rd_en_q       <= 1'b1;
                        rd_slot_q     <= 1'b0;
                        rd_addr_q     <= bus.i_base_addr;
                        rows_issued_q <= RW'(1);
                    end
                end
                StFill: begin
                    fill_q <= fill_q + 2'd1;
                    if (fill_q == 2'd0 && rows_needed_q > RW'(1)) begin
                        rd_en_q       <= 1'b1;
                        rd_slot_q     <= 1'b1;
                        rd_addr_q     <= rd_addr_q + ADDR_W'(1);
                        rows_issued_q <= RW'(2);
                    end
                end
                StRun: begin
                    if (hs) begin
                        p_q   <= p_next;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (refill) begin
                            rd_en_q       <= 1'b1;
                            rd_slot_q     <= slot_p;
                            rd_addr_q     <= rd_addr_q + ADDR_W'(1);
                            rows_issued_q <= rows_issued_q + RW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sb_unpack_ctrl.sv
// tb_sb_unpack_ctrl: directed bench for sb_unpack_ctrl with an SB memory and unpacker model.
module tb_sb_unpack_ctrl;
    localparam int unsigned N  = 16;
    localparam int unsigned SB = 5;
    localparam int unsigned AW = 10;
    localparam int unsigned CW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sb_unpack_ctrl_if #(.N(N), .SHIFT_BITS(SB), .ADDR_W(AW), .CNT_W(CW)) bus ();

    sb_unpack_ctrl #(.N(N), .SHIFT_BITS(SB), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // SB memory (1-cycle read latency) and unpacker ping-pong register
    logic [15:0] mem [0:1023];
    logic [15:0] sb_q;
    logic [31:0] ureg;
    always @(posedge clk) begin
        if (bus.o_rd_en) sb_q <= mem[bus.o_rd_addr];
        if (bus.o_load[0]) ureg[15:0] <= sb_q;
        if (bus.o_load[1]) ureg[31:16] <= sb_q;
    end

    int n_checks = 0;
    int n_fails  = 0;

    logic [15:0] got_val [$];
    logic [4:0]  got_s   [$];
    int          got_cyc [$];
    logic [9:0]  rd_addrs[$];
    int          done_cyc;
    logic        busy1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] unpack_out(input logic [31:0] r, input logic [4:0] s,
                                               input logic [4:0] n, input logic [15:0] se,
                                               input logic [15:0] ze);
        logic [63:0] d;
        logic [15:0] raw;
        d   = {32'h0, r, r} >> s;
        raw = d[15:0];
        return (raw & ~se & ze) | (raw[n - 5'd1] ? se : 16'h0);
    endfunction

    function automatic logic [31:0] gv(input int i);
        if (i < got_val.size()) return 32'(got_val[i]);
        return 32'hBAD0;
    endfunction
    function automatic logic [31:0] gs(input int i);
        if (i < got_s.size()) return 32'(got_s[i]);
        return 32'hBAD1;
    endfunction
    function automatic logic [31:0] gc(input int i);
        if (i < got_cyc.size()) return 32'(got_cyc[i]);
        return 32'hBAD2;
    endfunction
    function automatic logic [31:0] ga(input int i);
        if (i < rd_addrs.size()) return 32'(rd_addrs[i]);
        return 32'hBAD3;
    endfunction

    // Cycle 0 is the i_start cycle; samples taken 2 time units after each rising edge.
    task automatic run_job(input logic [9:0] base, input logic [11:0] cnt, input logic [4:0] prec,
                           input logic sgn, input logic [63:0] stall, input bit poke,
                           input int abort_at);
        bit         prev_stall;
        logic [4:0] prev_s;
        got_val.delete();
        got_s.delete();
        got_cyc.delete();
        rd_addrs.delete();
        done_cyc   = -1;
        busy1      = 1'b0;
        prev_stall = 1'b0;
        prev_s     = '0;
        @(posedge clk);
        #1;
        bus.i_start     = 1'b1;
        bus.i_base_addr = base;
        bus.i_count     = cnt;
        bus.i_prec      = prec;
        bus.i_signed    = sgn;
        bus.i_ready     = !stall[0];
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
                bus.i_start = poke && (cyc == 2);
                bus.i_count = (poke && cyc == 2) ? 12'd5 : cnt;
                bus.i_ready = !stall[cyc];
            end
            #1;
            if (cyc == abort_at) return;
            if (cyc == 1) busy1 = bus.o_busy;
            if (bus.o_rd_en) rd_addrs.push_back(bus.o_rd_addr);
            if (prev_stall) begin
                check_eq("hold_valid", 32'(bus.o_valid), 32'd1);
                check_eq("hold_s", 32'(bus.o_s), 32'(prev_s));
            end
            if (bus.o_valid && bus.i_ready) begin
                got_val.push_back(unpack_out(ureg, bus.o_s, prec, bus.o_se, bus.o_ze));
                got_s.push_back(bus.o_s);
                got_cyc.push_back(cyc);
            end
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_s     = bus.o_s;
            if (bus.o_done) begin
                done_cyc = cyc;
                break;
            end
        end
        bus.i_start = 1'b0;
        bus.i_ready = 1'b1;
        if (done_cyc < 0) check_eq("job_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_ctl"}, 32'({bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_load, bus.o_valid}),
                 32'd0);
        check_eq({tag, "_addr_s_n"}, 32'({bus.o_rd_addr, bus.o_s, bus.o_n}), 32'd0);
        check_eq({tag, "_masks"}, {bus.o_se, bus.o_ze}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        mem[10'h010] = 16'hA001;
        mem[10'h011] = 16'h0B02;
        mem[10'h012] = 16'hC003;
        mem[10'h3FF] = 16'h4321;
        mem[10'h000] = 16'h8765;
        mem[10'h100] = 16'hF555;
        mem[10'h101] = 16'h000F;
        bus.i_start     = 1'b0;
        bus.i_base_addr = '0;
        bus.i_count     = '0;
        bus.i_prec      = '0;
        bus.i_signed    = 1'b0;
        bus.i_ready     = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;

        // n=16 signed, 3 values: slot0 refill stall before the third
        run_job(10'h010, 12'd3, 5'd16, 1'b1, 64'h0, 1'b0, -1);
        check_eq("t1_nvals", 32'(got_val.size()), 32'd3);
        check_eq("t1_v0", gv(0), 32'hA001);
        check_eq("t1_v1", gv(1), 32'h0B02);
        check_eq("t1_v2", gv(2), 32'hC003);
        check_eq("t1_c0", gc(0), 32'd4);
        check_eq("t1_c1", gc(1), 32'd5);
        check_eq("t1_c2", gc(2), 32'd7);
        check_eq("t1_nreads", 32'(rd_addrs.size()), 32'd3);
        check_eq("t1_addr2", ga(2), 32'h012);
        check_eq("t1_done", 32'(done_cyc), 32'd8);
        check_eq("t1_busy", 32'(busy1), 32'd1);
        check_eq("t1_masks", {bus.o_se, bus.o_ze}, 32'h0000_FFFF);
        check_eq("t1_n", 32'(bus.o_n), 32'd0);

        // n=4 unsigned, 8 values, address wrap, i_start while busy
        run_job(10'h3FF, 12'd8, 5'd4, 1'b0, 64'h0, 1'b1, -1);
        check_eq("t2_nvals", 32'(got_val.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t2_v%0d", i), gv(i), 32'(i + 1));
            check_eq($sformatf("t2_c%0d", i), gc(i), 32'(i + 4));
        end
        check_eq("t2_nreads", 32'(rd_addrs.size()), 32'd2);
        check_eq("t2_addr0", ga(0), 32'h3FF);
        check_eq("t2_addr1", ga(1), 32'h000);
        check_eq("t2_done", 32'(done_cyc), 32'd12);
        check_eq("t2_masks", {bus.o_se, bus.o_ze}, 32'h0000_000F);
        check_eq("t2_n", 32'(bus.o_n), 32'd4);

        // n=10 signed, -3 straddling rows
        run_job(10'h100, 12'd2, 5'd10, 1'b1, 64'h0, 1'b0, -1);
        check_eq("t3_v0", gv(0), 32'h0155);
        check_eq("t3_v1", gv(1), 32'hFFFD);
        check_eq("t3_s1", gs(1), 32'd10);
        check_eq("t3_masks", {bus.o_se, bus.o_ze}, 32'hFC00_FFFF);
        check_eq("t3_n", 32'(bus.o_n), 32'd10);

        // i_ready low in cycles 6..8
        run_job(10'h3FF, 12'd8, 5'd4, 1'b0, 64'h1C0, 1'b0, -1);
        check_eq("t4_nvals", 32'(got_val.size()), 32'd8);
        for (int i = 0; i < 8; i++) check_eq($sformatf("t4_v%0d", i), gv(i), 32'(i + 1));
        check_eq("t4_c2", gc(2), 32'd9);
        check_eq("t4_c7", gc(7), 32'd14);
        check_eq("t4_nreads", 32'(rd_addrs.size()), 32'd2);
        check_eq("t4_done", 32'(done_cyc), 32'd15);

        // count=0
        run_job(10'h050, 12'd0, 5'd4, 1'b0, 64'h0, 1'b0, -1);
        check_eq("t5_done", 32'(done_cyc), 32'd1);
        check_eq("t5_nreads", 32'(rd_addrs.size()), 32'd0);
        check_eq("t5_busy", 32'(busy1), 32'd0);
        check_eq("t5_nvals", 32'(got_val.size()), 32'd0);

        // reset mid-RUN, then a fresh job
        run_job(10'h010, 12'd3, 5'd16, 1'b1, 64'h0, 1'b0, 5);
        rst = 1'b1;
        #1;
        check_idle_zero("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_job(10'h100, 12'd2, 5'd10, 1'b1, 64'h0, 1'b0, -1);
        check_eq("t6_nvals", 32'(got_val.size()), 32'd2);
        check_eq("t6_v0", gv(0), 32'h0155);
        check_eq("t6_v1", gv(1), 32'hFFFD);
        check_eq("t6_c1", gc(1), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
